// File: rtl/sphincs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sphincs_pkg
//  Description : Shared SPHINCS+ constants. Holds the WOTS+ parameters,
//                the address field offsets, the F-function message length
//                and the wots_pk_from_sig state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sphincs_pkg;

    // WOTS+ parameters (w = 16, 4-bit digits)
    localparam int WOTS_W     = 16;
    localparam int WOTS_LOG_W = 4;
    localparam int WOTS_LEN1  = 64;
    localparam int WOTS_LEN2  = 3;
    localparam int WOTS_LEN   = WOTS_LEN1 + WOTS_LEN2;

    // Address field positions inside the 256-bit ADRS word
    localparam int ADDR_CHAIN_HI = 119;
    localparam int ADDR_CHAIN_LO = 112;
    localparam int ADDR_HASH_HI  = 87;
    localparam int ADDR_HASH_LO  = 80;

    // Byte length of one F-function message (pub_seed block excluded)
    localparam logic [6:0] F_LEN_BYTES = 7'd54;

    // Chain recovery state encoding
    localparam int         STATE_W = 3;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CSUM  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_ISSUE = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
    localparam logic [2:0] S_EMIT  = 3'd6;

endpackage
`default_nettype wire

// File: rtl/wots_csum.sv
`default_nettype none
// ============================================================================
//  Module      : wots_csum
//  Description : WOTS+ checksum accumulator and chain-length digit mux.
//                Latches the digest on i_load, accumulates (15 - digit)
//                over 64 i_step cycles, and returns lengths[i_idx].
//  Revision    : 1.0 - initial release
// ============================================================================
module wots_csum
    import sphincs_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_step,
    input  logic [255:0] i_msg,
    input  logic [7:0]   i_idx,
    output logic [3:0]   o_digit
);

    logic [255:0] r_msg;      // digest copy used by the digit mux
    logic [255:0] r_shift;    // shifting copy consumed by the accumulator
    logic [11:0]  r_csum;     // max 64 * 15 = 960, fits in 12 bits
    logic [3:0]   w_top_inv;
    logic [255:0] w_msg_sel;

    assign w_top_inv = 4'hF - r_shift[255:252];
    assign w_msg_sel = r_msg << {i_idx[5:0], 2'b00};

    // Latch the digest and accumulate one checksum term per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msg   <= '0;
            r_shift <= '0;
            r_csum  <= '0;
        end else if (i_load) begin
            r_msg   <= i_msg;
            r_shift <= i_msg;
            r_csum  <= '0;
        end else if (i_step) begin
            r_csum  <= r_csum + {8'd0, w_top_inv};
            r_shift <= {r_shift[251:0], 4'd0};
        end
    end

    // Message digits first, then the three checksum nibbles MSB first
    always_comb begin
        o_digit = 4'd0;
        if (i_idx < 8'(WOTS_LEN1)) begin
            o_digit = w_msg_sel[255:252];
        end else if (i_idx == 8'(WOTS_LEN1)) begin
            o_digit = r_csum[11:8];
        end else if (i_idx == 8'(WOTS_LEN1 + 1)) begin
            o_digit = r_csum[7:4];
        end else begin
            o_digit = r_csum[3:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/wots_pk_from_sig.sv
`default_nettype none
// ============================================================================
//  Module      : wots_pk_from_sig
//  Description : WOTS+ public key recovery. Completes each of the 67 chains
//                from its signature element through the shared SHA-256
//                core and streams the chain ends to the ltree stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module wots_pk_from_sig
    import sphincs_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] msg,
    input  logic [255:0] seed_state,
    input  logic [255:0] wots_addr,
    output logic         sig_req,
    input  logic         sig_vld,
    input  logic [255:0] sig_din,
    output logic         sha256_start,
    output logic         sha256_1st,
    output logic         sha256_final,
    output logic [255:0] sha256_state,
    output logic [511:0] sha256_data,
    output logic [6:0]   sha256_len,
    input  logic         sha256_done,
    input  logic [255:0] sha256_dout,
    output logic         pk_vld,
    output logic [255:0] pk_dout,
    output logic [7:0]   pk_idx,
    output logic         busy,
    output logic         done
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;

    logic [255:0] r_addr;
    logic [255:0] r_seed;
    logic [255:0] r_val;        // current chain value
    logic [255:0] r_pk_dout;
    logic [7:0]   r_pk_idx;
    logic [3:0]   r_hash_cnt;   // chain position of r_val
    logic [5:0]   r_csum_cnt;
    logic [6:0]   r_len;
    logic         r_pk_vld;
    logic         r_done;
    logic         r_busy;

    logic         w_start_ok;
    logic         w_last_chain;
    logic         w_chain_end;
    logic [3:0]   w_digit;
    logic         w_unused;

    // Chain and hash fields are replaced by live counters
    assign w_unused = ^{wots_addr[ADDR_CHAIN_HI:ADDR_CHAIN_LO],
                        wots_addr[ADDR_HASH_HI:ADDR_HASH_LO]};

    assign w_start_ok   = (r_state == S_IDLE) && start && !r_busy;
    assign w_last_chain = (r_pk_idx == 8'(WOTS_LEN - 1));
    assign w_chain_end  = (r_hash_cnt == 4'(WOTS_W - 1));

    wots_csum u_csum (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_start_ok),
        .i_step  (r_state == S_CSUM),
        .i_msg   (msg),
        .i_idx   (r_pk_idx),
        .o_digit (w_digit)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived handshake outputs
    always_comb begin
        w_state_nxt  = r_state;
        sig_req      = 1'b0;
        sha256_start = 1'b0;
        sha256_1st   = 1'b0;
        sha256_final = 1'b0;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_CSUM;
            S_CSUM:  if (r_csum_cnt == 6'(WOTS_LEN1 - 1)) w_state_nxt = S_FETCH;
            S_FETCH: begin
                sig_req = 1'b1;
                if (sig_vld) w_state_nxt = S_CHECK;
            end
            S_CHECK: w_state_nxt = w_chain_end ? S_EMIT : S_ISSUE;
            S_ISSUE: begin
                sha256_start = 1'b1;
                sha256_1st   = 1'b1;
                sha256_final = 1'b1;
                w_state_nxt  = S_WAIT;
            end
            S_WAIT:  if (sha256_done) w_state_nxt = S_CHECK;
            S_EMIT:  w_state_nxt = w_last_chain ? S_IDLE : S_FETCH;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand latch, chain stepping and result emission
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_seed     <= '0;
            r_val      <= '0;
            r_pk_dout  <= '0;
            r_pk_idx   <= '0;
            r_hash_cnt <= '0;
            r_csum_cnt <= '0;
            r_len      <= '0;
            r_pk_vld   <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_len    <= F_LEN_BYTES;
            r_pk_vld <= 1'b0;
            r_done   <= 1'b0;
            if (r_done) r_busy <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_addr     <= wots_addr;
                        r_seed     <= seed_state;
                        r_pk_idx   <= '0;
                        r_hash_cnt <= '0;
                        r_csum_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_CSUM: r_csum_cnt <= r_csum_cnt + 6'd1;
                S_FETCH: begin
                    if (sig_vld) begin
                        r_val      <= sig_din;
                        r_hash_cnt <= w_digit;
                    end
                end
                S_CHECK: begin
                    // pk_vld is registered so it is high during EMIT
                    if (w_chain_end) begin
                        r_pk_vld  <= 1'b1;
                        r_pk_dout <= r_val;
                    end
                end
                S_WAIT: begin
                    if (sha256_done) begin
                        r_val      <= sha256_dout;
                        r_hash_cnt <= r_hash_cnt + 4'd1;
                    end
                end
                S_EMIT: begin
                    if (w_last_chain) r_done <= 1'b1;
                    else              r_pk_idx <= r_pk_idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign sha256_state = r_seed;
    assign sha256_data  = {r_addr[255:ADDR_CHAIN_HI+1], r_pk_idx,
                           r_addr[ADDR_CHAIN_LO-1:ADDR_HASH_HI+1],
                           {4'd0, r_hash_cnt}, r_val,
                           r_addr[ADDR_HASH_LO-1:0]};
    assign sha256_len   = r_len;
    assign pk_vld       = r_pk_vld;
    assign pk_dout      = r_pk_dout;
    assign pk_idx       = r_pk_idx;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_wots_pk_from_sig.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wots_pk_from_sig
//  Description : Self-checking bench for wots_pk_from_sig. Acts as the
//                signature reader and as a stand-in compression core, and
//                compares every chain end with a reference chain model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wots_pk_from_sig;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [255:0] msg = '0;
    logic [255:0] seed_state = '0;
    logic [255:0] wots_addr = '0;
    logic         sig_req;
    logic         sig_vld = 1'b0;
    logic [255:0] sig_din = '0;
    logic         sha256_start;
    logic         sha256_1st;
    logic         sha256_final;
    logic [255:0] sha256_state;
    logic [511:0] sha256_data;
    logic [6:0]   sha256_len;
    logic         sha256_done = 1'b0;
    logic [255:0] sha256_dout = '0;
    logic         pk_vld;
    logic [255:0] pk_dout;
    logic [7:0]   pk_idx;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    wots_pk_from_sig dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .msg          (msg),
        .seed_state   (seed_state),
        .wots_addr    (wots_addr),
        .sig_req      (sig_req),
        .sig_vld      (sig_vld),
        .sig_din      (sig_din),
        .sha256_start (sha256_start),
        .sha256_1st   (sha256_1st),
        .sha256_final (sha256_final),
        .sha256_state (sha256_state),
        .sha256_data  (sha256_data),
        .sha256_len   (sha256_len),
        .sha256_done  (sha256_done),
        .sha256_dout  (sha256_dout),
        .pk_vld       (pk_vld),
        .pk_dout      (pk_dout),
        .pk_idx       (pk_idx),
        .busy         (busy),
        .done         (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Stand-in compression function: depends on state, address fields and value
    function automatic logic [255:0] fake_f(input logic [255:0] st, input logic [511:0] d);
        logic [255:0] v;
        v = d[335:80];
        return ({v[250:0], v[255:251]} ^ st ^ d[511:256]) + d[255:0];
    endfunction

    function automatic logic [3:0] m_digit(input logic [255:0] m, input int i);
        int cs;
        cs = 0;
        if (i < 64) return m[255-4*i -: 4];
        for (int k = 0; k < 64; k++) cs += 15 - int'(m[255-4*k -: 4]);
        if (i == 64) return cs[11:8];
        if (i == 65) return cs[7:4];
        return cs[3:0];
    endfunction

    function automatic logic [511:0] m_data(input logic [255:0] a, input int i, input int h,
                                            input logic [255:0] v);
        logic [7:0] ci;
        logic [7:0] hi;
        ci = 8'(i);
        hi = 8'(h);
        return {a[255:120], ci, a[111:88], hi, v, a[79:0]};
    endfunction

    function automatic logic [255:0] m_elem(input logic [7:0] i, input logic [255:0] salt);
        return {32{i}} ^ salt;
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- environment state ----------------
    logic [255:0] cur_msg, cur_seed, cur_addr, cur_salt;
    logic [255:0] exp_pk [67];
    int           mlen [67];
    int           exp_idx, cur_h, hash_total, pk_cnt, done_cnt, first_h64;
    bit           mon_en = 1'b0;
    int           max_delay = 0;
    bit           noise = 1'b0;
    int           lat = 1;
    bit           core_pending = 1'b0;
    int           core_wait = 0;
    logic [255:0] core_res;
    logic [511:0] core_data;
    bit           sig_waiting = 1'b0;
    int           sig_delay = 0;

    // One cycle of signature reader, compression core and output monitor
    task automatic mon_step();
        if (sig_vld) sig_vld = 1'b0;
        if (sha256_done) sha256_done = 1'b0;

        if (pk_vld) begin
            if (exp_idx < 67) begin
                chk("pk_idx", pk_idx, exp_idx);
                chk("pk_dout", pk_dout, exp_pk[exp_idx]);
                chk("chain_hash_count", cur_h, 15);
            end else begin
                chk("pk_extra", exp_idx, 66);
            end
            exp_idx++;
            if (exp_idx < 67) cur_h = mlen[exp_idx];
            pk_cnt++;
        end
        if (done) begin
            done_cnt++;
            chk("done_after_67", pk_cnt, 67);
        end

        if (core_pending) begin
            chk("sha_data_stable", sha256_data, core_data);
            if (core_wait == 0) begin
                sha256_done  = 1'b1;
                sha256_dout  = core_res;
                core_pending = 1'b0;
            end else begin
                core_wait--;
            end
        end
        if (sha256_start) begin
            chk("sha_1st", sha256_1st, 1);
            chk("sha_final", sha256_final, 1);
            chk("sha_len", sha256_len, 54);
            chk("sha_state", sha256_state, cur_seed);
            chk("sha_chain_field", sha256_data[375:368], exp_idx);
            chk("sha_hash_field", sha256_data[343:336], cur_h);
            if (exp_idx == 64 && first_h64 < 0) first_h64 = int'(sha256_data[343:336]);
            cur_h++;
            hash_total++;
            core_res     = fake_f(sha256_state, sha256_data);
            core_data    = sha256_data;
            core_pending = 1'b1;
            core_wait    = lat;
            if (noise) begin
                // done while still in ISSUE must be ignored
                sha256_done = 1'b1;
                sha256_dout = rnd256();
            end
        end

        if (sig_waiting) begin
            chk("sig_req_held", sig_req, 1);
            if (!sig_req) sig_waiting = 1'b0;
        end
        if (sig_req) begin
            if (!sig_waiting) begin
                sig_waiting = 1'b1;
                sig_delay   = $urandom_range(0, max_delay);
            end
            if (sig_delay == 0) begin
                sig_vld     = 1'b1;
                sig_din     = m_elem(pk_idx, cur_salt);
                sig_waiting = 1'b0;
            end else begin
                sig_delay--;
            end
        end else if (noise && $urandom_range(0, 2) == 0) begin
            sig_vld = 1'b1;
            sig_din = rnd256();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) mon_step();
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [255:0] msg;
        int           max_delay;
        bit           noise;
        bit           busy_start;
        int           exp_hashes;
        int           exp_h64;
    } vec_t;

    vec_t vecs [6];

    task automatic setup_run(input logic [255:0] m);
        logic [255:0] v;
        cur_msg  = m;
        cur_seed = rnd256();
        cur_addr = rnd256();
        cur_salt = rnd256();
        for (int i = 0; i < 67; i++) begin
            mlen[i] = int'(m_digit(cur_msg, i));
            v = m_elem(8'(i), cur_salt);
            for (int h = mlen[i]; h < 15; h++) v = fake_f(cur_seed, m_data(cur_addr, i, h, v));
            exp_pk[i] = v;
        end
        exp_idx = 0; cur_h = mlen[0]; hash_total = 0; pk_cnt = 0; done_cnt = 0;
        first_h64 = -1; core_pending = 1'b0; sig_waiting = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        msg = cur_msg; seed_state = cur_seed; wots_addr = cur_addr; start = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        int cyc;
        max_delay = v.max_delay;
        noise     = v.noise;
        setup_run(v.msg);
        k = 1;
        while (!sig_req && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (k == 2) begin
                start = 1'b0;
                chk("busy_after_start", busy, 1);
            end
            if (v.busy_start && k == 10) begin
                start = 1'b1; msg = ~cur_msg; seed_state = ~cur_seed; wots_addr = ~cur_addr;
            end
            if (k == 11) start = 1'b0;
        end
        chk("start_to_sig_req", k, 66);
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", done, 1);
        chk("busy_in_done", busy, 1);
        @(posedge clk); #1;
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("done_count", done_cnt, 1);
        chk("pk_count", pk_cnt, 67);
        chk("hash_total", hash_total, v.exp_hashes);
        chk("chain64_first_hash", first_h64, v.exp_h64);
    endtask

    initial begin
        vecs[0] = '{msg: '1,                          max_delay: 0,  noise: 1'b0, busy_start: 1'b0, exp_hashes: 45,  exp_h64: 0};
        vecs[1] = '{msg: '0,                          max_delay: 0,  noise: 1'b1, busy_start: 1'b0, exp_hashes: 990, exp_h64: 3};
        vecs[2] = '{msg: {4{64'h0123456789ABCDEF}},   max_delay: 20, noise: 1'b1, busy_start: 1'b0, exp_hashes: 510, exp_h64: 1};
        vecs[3] = '{msg: {64{4'h8}},                  max_delay: 5,  noise: 1'b0, busy_start: 1'b1, exp_hashes: 480, exp_h64: 1};
        vecs[4] = '{msg: {4{64'hFEDCBA9876543210}},   max_delay: 3,  noise: 1'b0, busy_start: 1'b0, exp_hashes: 510, exp_h64: 1};
        vecs[5] = '{msg: {4'h0, {62{4'hF}}, 4'h0},    max_delay: 20, noise: 1'b1, busy_start: 1'b1, exp_hashes: 60,  exp_h64: 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sig_req", sig_req, 0);
        chk("rst_sha_start", sha256_start, 0);
        chk("rst_sha_len", sha256_len, 0);
        chk("rst_pk_vld", pk_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("len_after_rst", sha256_len, 54);

        for (int i = 0; i < 6; i++) begin
            lat = i % 3;
            run_vec(vecs[i]);
        end

        // Reset during WAIT of chain 10
        begin
            int cyc;
            lat = 2; max_delay = 2; noise = 1'b0;
            setup_run('0);
            @(posedge clk); #1;
            start = 1'b0;
            cyc = 0;
            while (!(exp_idx == 10 && core_pending) && cyc < 20000) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("reached_chain10_wait", exp_idx, 10);
            @(posedge clk); #1;
            rst = 1'b1;
            #1;
            mon_en = 1'b0; sha256_done = 1'b0; sig_vld = 1'b0; core_pending = 1'b0;
            chk("mid_rst_sig_req", sig_req, 0);
            chk("mid_rst_sha_start", {sha256_start, sha256_1st, sha256_final}, 0);
            chk("mid_rst_sha_state", sha256_state, 0);
            chk("mid_rst_sha_data", sha256_data, 0);
            chk("mid_rst_sha_len", sha256_len, 0);
            chk("mid_rst_pk", {pk_vld, pk_dout, pk_idx}, 0);
            chk("mid_rst_busy_done", {busy, done}, 0);
            repeat (3) begin
                @(posedge clk); #1;
                chk("mid_rst_no_done", done, 0);
            end
            @(negedge clk);
            rst = 1'b0;
            lat = 1;
            run_vec(vecs[2]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
